// File: rtl/float_pkg.sv
// Shared types and helpers for the sequential float adder/subtractor.
package float_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAlign,
    StAdd,
    StNorm,
    StRound,
    StHold
  } state_e;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } flags_t;

  typedef enum logic [1:0] {
    ClsZero,
    ClsNormal,
    ClsInf,
    ClsNan
  } fclass_e;

  // Width-agnostic: the caller reduces its own exponent/fraction fields to these three facts.
  function automatic fclass_e fclass_decode(input logic exp_zero, input logic exp_ones,
                                            input logic frac_zero);
    if (exp_zero) return ClsZero;
    if (!exp_ones) return ClsNormal;
    return frac_zero ? ClsInf : ClsNan;
  endfunction

  // Quiet NaN {0, all-ones exponent, 1 followed by zeros}, right-aligned in 64 bits.
  function automatic logic [63:0] qnan_word(input int unsigned exp_w, input int unsigned man_w);
    logic [63:0] w;
    w = '0;
    for (int unsigned i = 0; i < exp_w; i++) begin
      w = w | (64'd1 << (man_w + i));
    end
    w = w | (64'd1 << (man_w - 1));
    return w;
  endfunction

endpackage

// File: rtl/float_addsub_seq_if.sv
// Operand/result handshake bundle for float_addsub_seq.
interface float_addsub_seq_if #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) ();
  import float_pkg::*;

  localparam int unsigned W = 1 + EXP_W + MAN_W;

  logic         IN_VALID;
  logic         IN_READY;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         OP;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic [W-1:0] RESULT;
  flags_t       FLAGS;

  modport slave (
    input  IN_VALID, A, B, OP, OUT_READY,
    output IN_READY, OUT_VALID, RESULT, FLAGS
  );

  modport master (
    output IN_VALID, A, B, OP, OUT_READY,
    input  IN_READY, OUT_VALID, RESULT, FLAGS
  );

endinterface

// File: rtl/float_align_shift.sv
// Right shift of a significand with every shifted-out bit folded into the sticky LSB.
module float_align_shift #(
  parameter int unsigned SigW = 27,
  parameter int unsigned AmtW = 8
) (
  input  logic [SigW-1:0] sig_i,
  input  logic [AmtW-1:0] amt_i,
  output logic [SigW-1:0] sig_o
);

  logic [SigW-1:0] shifted;
  logic [SigW-1:0] lost_mask;

  assign shifted   = sig_i >> amt_i;
  // Oversized shifts give an all-ones mask, leaving only the sticky bit.
  assign lost_mask = ~({SigW{1'b1}} << amt_i);
  assign sig_o     = {shifted[SigW-1:1], shifted[0] | (|(sig_i & lost_mask))};

endmodule

// File: rtl/float_addsub_seq.sv
// Multi-cycle IEEE-style adder/subtractor, round-to-nearest-even, subnormals flushed to zero.
module float_addsub_seq
  import float_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input logic               CLK,
  input logic               RESET_N,
  float_addsub_seq_if.slave bus
);

  localparam int unsigned W  = 1 + EXP_W + MAN_W;
  localparam int unsigned DW = MAN_W + 4;  // hidden bit, fraction, guard, round, sticky
  localparam int unsigned SW = MAN_W + 5;
  localparam logic [63:0]    QNAN_WORD = qnan_word(EXP_W, MAN_W);
  localparam logic [W-1:0]   QNAN      = QNAN_WORD[W-1:0];
  localparam logic [EXP_W:0] EXP_MAX   = {1'b0, {EXP_W{1'b1}}};
  localparam logic [EXP_W:0] EXP_ONE   = (EXP_W+1)'(1);

  state_e         state_q, state_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d, result_q, result_d;
  flags_t         flags_q, flags_d;
  logic           sign_q, sign_d, sub_q, sub_d;
  logic [EXP_W:0] exp_q, exp_d;
  logic [DW-1:0]  man_q, man_d, mb_q, mb_d;
  logic           in_ready_q, out_valid_q;

  assign bus.IN_READY  = in_ready_q;
  assign bus.OUT_VALID = out_valid_q;
  assign bus.RESULT    = result_q;
  assign bus.FLAGS     = flags_q;

  // Input classification and special-value bypass
  logic [W-1:0] in_a, in_b, spec_res;
  fclass_e      cls_a, cls_b;
  flags_t       spec_flags;
  logic         is_special;

  assign in_a  = bus.A;
  assign in_b  = {bus.B[W-1] ^ bus.OP, bus.B[W-2:0]};
  assign cls_a = fclass_decode(in_a[W-2:MAN_W] == '0, in_a[W-2:MAN_W] == '1,
                               in_a[MAN_W-1:0] == '0);
  assign cls_b = fclass_decode(in_b[W-2:MAN_W] == '0, in_b[W-2:MAN_W] == '1,
                               in_b[MAN_W-1:0] == '0);

  always_comb begin
    spec_res   = in_a;
    spec_flags = '0;
    is_special = (cls_a != ClsNormal) || (cls_b != ClsNormal);
    if (cls_a == ClsNan || cls_b == ClsNan) begin
      spec_res = QNAN;
    end else if (cls_a == ClsInf && cls_b == ClsInf) begin
      if (in_a[W-1] != in_b[W-1]) begin
        spec_res           = QNAN;
        spec_flags.invalid = 1'b1;
      end
    end else if (cls_a == ClsInf) begin
      spec_res = in_a;
    end else if (cls_b == ClsInf) begin
      spec_res = in_b;
    end else if (cls_a == ClsZero && cls_b == ClsZero) begin
      spec_res = {in_a[W-1] & in_b[W-1], {(W-1){1'b0}}};
    end else if (cls_a == ClsZero) begin
      spec_res = in_b;
    end
  end

  // Alignment: larger magnitude first, smaller one shifted down
  logic           a_big;
  logic [W-1:0]   big_op;
  logic [W-2:0]   small_mag;
  logic [EXP_W-1:0] shift_amt;
  logic [DW-1:0]  small_sig, small_aligned;

  assign a_big     = a_q[W-2:0] >= b_q[W-2:0];
  assign big_op    = a_big ? a_q : b_q;
  assign small_mag = a_big ? b_q[W-2:0] : a_q[W-2:0];
  assign shift_amt = big_op[W-2:MAN_W] - small_mag[W-2:MAN_W];
  assign small_sig = {1'b1, small_mag[MAN_W-1:0], 3'b000};

  float_align_shift #(
    .SigW (DW),
    .AmtW (EXP_W)
  ) u_align (
    .sig_i (small_sig),
    .amt_i (shift_amt),
    .sig_o (small_aligned)
  );

  // Magnitude add; subtraction never goes negative because of the swap
  logic [SW-1:0] sum;
  assign sum = sub_q ? ({1'b0, man_q} - {1'b0, mb_q}) : ({1'b0, man_q} + {1'b0, mb_q});

  logic [DW-1:0] man_shl;
  assign man_shl = {man_q[DW-2:0], 1'b0};

  // Rounding from guard/round/sticky in man_q[2:0]
  logic             round_up, inexact;
  logic [MAN_W+1:0] rounded;
  logic [EXP_W:0]   exp_rnd;
  logic [MAN_W-1:0] frac_rnd;

  assign inexact  = |man_q[2:0];
  assign round_up = man_q[2] & (man_q[1] | man_q[0] | man_q[3]);
  assign rounded  = {1'b0, man_q[DW-1:3]} + {{(MAN_W+1){1'b0}}, round_up};
  assign exp_rnd  = exp_q + {{EXP_W{1'b0}}, rounded[MAN_W+1]};
  assign frac_rnd = rounded[MAN_W+1] ? rounded[MAN_W:1] : rounded[MAN_W-1:0];

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sign_d   = sign_q;
    sub_d    = sub_q;
    exp_d    = exp_q;
    man_d    = man_q;
    mb_d     = mb_q;
    result_d = result_q;
    flags_d  = flags_q;
    unique case (state_q)
      StIdle: begin
        if (bus.IN_VALID && in_ready_q) begin
          a_d = in_a;
          b_d = in_b;
          if (is_special) begin
            result_d = spec_res;
            flags_d  = spec_flags;
            state_d  = StHold;
          end else begin
            state_d = StAlign;
          end
        end
      end
      StAlign: begin
        sign_d  = big_op[W-1];
        sub_d   = a_q[W-1] ^ b_q[W-1];
        exp_d   = {1'b0, big_op[W-2:MAN_W]};
        man_d   = {1'b1, big_op[MAN_W-1:0], 3'b000};
        mb_d    = small_aligned;
        state_d = StAdd;
      end
      StAdd: begin
        if (sum[SW-1]) begin
          man_d   = {sum[SW-1:2], sum[1] | sum[0]};
          exp_d   = exp_q + EXP_ONE;
          state_d = StRound;
        end else begin
          man_d   = sum[DW-1:0];
          state_d = sum[DW-1] ? StRound : StNorm;
        end
      end
      StNorm: begin
        if (man_q == '0) begin
          sign_d  = 1'b0;
          exp_d   = '0;
          state_d = StRound;
        end else if (exp_q <= EXP_ONE) begin
          result_d          = {sign_q, {(W-1){1'b0}}};
          flags_d           = '0;
          flags_d.underflow = 1'b1;
          flags_d.inexact   = 1'b1;
          state_d           = StHold;
        end else begin
          man_d = man_shl;
          exp_d = exp_q - EXP_ONE;
          if (man_shl[DW-1]) state_d = StRound;
        end
      end
      StRound: begin
        flags_d         = '0;
        flags_d.inexact = inexact;
        if (exp_rnd >= EXP_MAX) begin
          result_d         = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          flags_d.overflow = 1'b1;
          flags_d.inexact  = 1'b1;
        end else begin
          result_d = {sign_q, exp_rnd[EXP_W-1:0], frac_rnd};
        end
        state_d = StHold;
      end
      StHold: begin
        if (bus.OUT_READY) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      sign_q      <= 1'b0;
      sub_q       <= 1'b0;
      exp_q       <= '0;
      man_q       <= '0;
      mb_q        <= '0;
      result_q    <= '0;
      flags_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sign_q      <= sign_d;
      sub_q       <= sub_d;
      exp_q       <= exp_d;
      man_q       <= man_d;
      mb_q        <= mb_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      in_ready_q  <= (state_d == StIdle);
      out_valid_q <= (state_d == StHold);
    end
  end

endmodule

// File: tb/tb_float_addsub_seq.sv
// Directed bench for float_addsub_seq: single-precision and half-precision instances.
module tb_float_addsub_seq;
  import float_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  float_addsub_seq_if #(.EXP_W(8), .MAN_W(23)) m ();
  float_addsub_seq_if #(.EXP_W(5), .MAN_W(10)) h ();

  float_addsub_seq #(.EXP_W(8), .MAN_W(23)) dut_m (.CLK(clk), .RESET_N(rst_n), .bus(m));
  float_addsub_seq #(.EXP_W(5), .MAN_W(10)) dut_h (.CLK(clk), .RESET_N(rst_n), .bus(h));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expd);
    n_checks++;
    assert (obs === expd) n_pass++;
    else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expd);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input bit half, input logic [31:0] a, input logic [31:0] b,
                          input logic op, input string tag);
    if (half) begin
      check({tag, " in_ready"}, h.IN_READY, 1);
      h.A = a[15:0]; h.B = b[15:0]; h.OP = op; h.IN_VALID = 1'b1;
    end else begin
      check({tag, " in_ready"}, m.IN_READY, 1);
      m.A = a; m.B = b; m.OP = op; m.IN_VALID = 1'b1;
    end
    tick();
    h.IN_VALID = 1'b0;
    m.IN_VALID = 1'b0;
    check({tag, " busy"}, half ? h.IN_READY : m.IN_READY, 0);
  endtask

  task automatic wait_out(input bit half, input int exp_lat, input string tag);
    int lat = 0;
    do begin
      tick();
      lat++;
    end while (!(half ? h.OUT_VALID : m.OUT_VALID) && lat < 64);
    check({tag, " latency"}, lat, exp_lat);
  endtask

  task automatic finish_op(input bit half, input string tag);
    h.OUT_READY = half;
    m.OUT_READY = !half;
    tick();
    h.OUT_READY = 1'b0;
    m.OUT_READY = 1'b0;
    check({tag, " out_valid_drop"}, half ? h.OUT_VALID : m.OUT_VALID, 0);
    check({tag, " ready_back"}, half ? h.IN_READY : m.IN_READY, 1);
  endtask

  task automatic run_op(input bit half, input logic [31:0] a, input logic [31:0] b,
                        input logic op, input logic [31:0] res, input logic [3:0] flg,
                        input int lat, input string tag);
    start_op(half, a, b, op, tag);
    wait_out(half, lat, tag);
    check({tag, " result"}, half ? 32'(h.RESULT) : m.RESULT, res);
    check({tag, " flags"}, half ? h.FLAGS : m.FLAGS, flg);
    finish_op(half, tag);
  endtask

  initial begin
    m.IN_VALID = 1'b0; m.A = '0; m.B = '0; m.OP = 1'b0; m.OUT_READY = 1'b0;
    h.IN_VALID = 1'b0; h.A = '0; h.B = '0; h.OP = 1'b0; h.OUT_READY = 1'b0;

    #12;
    check("rst in_ready", m.IN_READY, 0);
    check("rst out_valid", m.OUT_VALID, 0);
    check("rst result", m.RESULT, 0);
    check("rst flags", m.FLAGS, 0);
    rst_n = 1'b1;
    tick();
    check("rst released in_ready", m.IN_READY, 1);
    check("rst released half in_ready", h.IN_READY, 1);

    run_op(0, 32'h3F80_0000, 32'h4000_0000, 0, 32'h4040_0000, 4'h0, 3, "add_1_2");
    run_op(0, 32'h3FC0_0000, 32'h3F80_0000, 1, 32'h3F00_0000, 4'h0, 4, "sub_norm1");
    run_op(0, 32'h3F80_0000, 32'h3F80_0000, 1, 32'h0000_0000, 4'h0, 4, "x_minus_x");
    run_op(0, 32'h3F80_0000, 32'h3380_0000, 0, 32'h3F80_0000, 4'h1, 3, "tie_even");
    run_op(0, 32'h3F80_0001, 32'h3380_0000, 0, 32'h3F80_0002, 4'h1, 3, "tie_odd");
    run_op(0, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 0, 32'h7F80_0000, 4'h5, 3, "overflow");
    run_op(0, 32'h7F80_0000, 32'h7F80_0000, 1, 32'h7FC0_0000, 4'h8, 1, "inf_minus_inf");
    run_op(0, 32'h7FC0_0001, 32'h3F80_0000, 0, 32'h7FC0_0000, 4'h0, 1, "nan_in");
    run_op(0, 32'hFF80_0000, 32'h3F80_0000, 0, 32'hFF80_0000, 4'h0, 1, "inf_plus_fin");
    run_op(0, 32'h8000_0000, 32'h0000_0000, 1, 32'h8000_0000, 4'h0, 1, "negzero");
    run_op(0, 32'h0080_0001, 32'h0080_0000, 1, 32'h0000_0000, 4'h3, 3, "underflow");

    // Consumer stalls; a new request during HOLD must be ignored
    start_op(0, 32'h3F80_0000, 32'h4000_0000, 0, "stall");
    wait_out(0, 3, "stall");
    for (int i = 0; i < 10; i++) begin
      if (i == 2) begin
        m.A = 32'h4100_0000; m.B = 32'h4100_0000; m.OP = 1'b0; m.IN_VALID = 1'b1;
      end
      if (i == 6) m.IN_VALID = 1'b0;
      tick();
      check("stall result", m.RESULT, 32'h4040_0000);
      check("stall in_ready", m.IN_READY, 0);
      check("stall out_valid", m.OUT_VALID, 1);
    end
    finish_op(0, "stall");
    repeat (4) tick();
    check("stall ignored req", m.OUT_VALID, 0);
    check("stall result kept", m.RESULT, 32'h4040_0000);

    // Abort while normalising a long cancellation
    start_op(0, 32'h3F80_0001, 32'h3F80_0000, 1, "abort");
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check("abort out_valid", m.OUT_VALID, 0);
    check("abort result", m.RESULT, 0);
    check("abort in_ready low", m.IN_READY, 0);
    #2;
    rst_n = 1'b1;
    tick();
    check("abort in_ready", m.IN_READY, 1);
    check("abort out_valid after", m.OUT_VALID, 0);
    check("abort flags", m.FLAGS, 0);

    run_op(0, 32'h3F80_0001, 32'h3F80_0000, 1, 32'h3400_0000, 4'h0, 26, "norm_k23");

    run_op(1, 32'h0000_3C00, 32'h0000_3C00, 0, 32'h0000_4000, 4'h0, 3, "half_1_1");
    run_op(1, 32'h0000_0400, 32'h0000_03FF, 1, 32'h0000_0400, 4'h0, 1, "half_flush");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
